vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Video-RAM arbiter and double-buffer scheduler between the VGA timing generator and a single-port synchronous frame-buffer RAM. It steals fixed read slots from the sampled `hc`/`vc` to prefetch 4-pixel words for scan-out. It grants all remaining RAM cycles to one writer through a valid/ready handshake. It swaps front and back buffers only at a frame boundary, on request.

## Interface
- `HPIXELS`, 800: horizontal count modulus; must match the timing generator.
- `VLINES`, 521: vertical count modulus.
- `WORDS_PER_LINE`, 160: scan reads per active line, 4 pixels per word.
- `FB_WORDS`, 76800: words per buffer.
- `ADDR_W`, 17: writer address width; the RAM address is `ADDR_W+1` bits.
- `clk` in 1: pixel clock, the same clock as the timing generator.
- `reset` in 1: synchronous, active-low; 0 = reset.
- `hc` in 10: horizontal count from the timing generator.
- `vc` in 10: vertical count from the timing generator.
- `wr_valid` in 1: writer request.
- `wr_ready` out 1: writer grant.
- `wr_addr` in ADDR_W: word address within the back buffer.
- `wr_data` in 32: write word; byte j = pixel j, RGB332.
- `wr_err` out 1: one-cycle pulse; an accepted write was dropped because it was out of range.
- `swap_req` in 1: level; the requester holds it until `swap_ack`.
- `swap_ack` out 1: one-cycle pulse; the swap is done.
- `front_sel` out 1: buffer currently scanned out.
- `ram_en` out 1: RAM command strobe.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W+1: RAM address, `{buffer, word}`.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid 1 cycle after a read.
- `pix_out` out 8: registered RGB332 pixel.

## Operation
- Active window:
  - Lines `vc` 37..515 (479 lines).
  - Pixels `hc` 152..790, giving x = `hc`−152.
- Scan slots:
  - A slot occurs when sampled `hc` = 148+4k (k = 0..159) and `vc` is in the active window.
  - In a slot the block drives `ram_en`=1, `ram_we`=0, `ram_addr`={`front_sel`, `scan_addr`}, all combinational.
  - `scan_addr` increments after each slot.
  - `scan_addr` clears on the edge where `vc`==0 and `hc`==0.
  - `scan_addr` never exceeds `FB_WORDS`−1 within a frame.
- Prefetch register: captures `ram_rdata` on the edge where `hc`==149+4k.
- Pixel shifter:
  - Loads the prefetch word on the edge where `hc`==151+4k.
  - `pix_out` takes byte 0 at that edge, then bytes 1, 2, 3 on the following edges.
  - `pix_out` is forced to 0 on any edge where the entered position (`hc`+1, `vc`) is outside the active window.
- Writer port:
  - `wr_ready` = `reset` & ~scan_slot, combinational.
  - A write is accepted when `wr_valid` & `wr_ready`.
  - On accept, the block drives `ram_en`=1, `ram_we`=1, `ram_addr`={~`front_sel`, `wr_addr`}, `ram_wdata`=`wr_data`.
  - If `wr_addr` ≥ `FB_WORDS`, the write is accepted but not issued (`ram_en`=0), and `wr_err` pulses on the next cycle.
- Swap FSM:
  - IDLE → PENDING when `swap_req`=1.
  - PENDING → ACK on the frame-end edge (`hc`==`HPIXELS`−1 and `vc`==`VLINES`−1). On that same edge `front_sel` toggles.
  - ACK → IDLE unconditionally. `swap_ack`=1 only in ACK.
  - If `swap_req` first rises on the frame-end edge itself, the FSM enters PENDING and the swap waits one full frame.
- Writes issued while PENDING still target the old back buffer. From the cycle after the toggle, writes target the new back buffer.

## Timing
- Reset values: `front_sel`=0, FSM=IDLE, `pix_out`=0, `swap_ack`=0, `wr_err`=0, `scan_addr`=0, prefetch and shifter cleared.
- While `reset`=0: `wr_ready`=0 and `ram_en`=0.
- Writer latency: the write reaches the RAM in the same cycle it is accepted.
- Writer bandwidth:
  - During active lines the writer gets 3 of every 4 cycles in `hc` 148..787.
  - Outside those cycles the writer gets every cycle.
- Pixel latency: slot issue to first pixel is 4 cycles (read at `hc`=148, pixel visible at `hc`=152).
- Reset mid-frame: scan-out resumes cleanly at the next frame, once `scan_addr` clears at `vc`=0.
- `swap_ack` asserts exactly 1 cycle after the frame-end edge.

## Structure
- Shared package `vga_pkg`:
  - Constants `HPIXELS`, `VLINES`, the active-window bounds, slot base 148.
  - FSM state encoding IDLE/PENDING/ACK.
- One sub-module: `fb_pixel_shifter`, containing the prefetch register, the 4-byte shifter and `pix_out` blanking.

## Test plan
- Reset held 0 for 5 cycles → `wr_ready`=0, `ram_en`=0, `pix_out`=0, `front_sel`=0.
- Writer holds `wr_valid`=1 across active line `vc`=37 → `wr_ready` low exactly at `hc` 148, 152, …, 784. Each write reaches `ram_addr` with MSB=1.
- RAM model returns 0x44332211 for front word 0 → `pix_out` = 0x11, 0x22, 0x33, 0x44 during `hc` 152..155 of `vc`=37. `pix_out`=0 at `hc`=151 and at `hc`=791.
- `swap_req` raised at `vc`=100 → `front_sel` flips on the edge after `hc`=799, `vc`=520. `swap_ack` pulses exactly once on that following cycle. Subsequent writes target buffer 0.
- `swap_req` first asserted on the frame-end edge → no swap for one full frame; the swap occurs at the next frame end.
- Write with `wr_addr`=76800 → accepted with `ram_en`=0; `wr_err` pulses 1 cycle later. `wr_addr`=76799 → issued normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and swap FSM encoding for the frame-buffer arbiter.
package vga_pkg;
    localparam int HPIXELS = 800;
    localparam int VLINES  = 521;

    localparam logic [9:0] V_ACT_FIRST = 10'd37;
    localparam logic [9:0] V_ACT_LAST  = 10'd515;
    localparam logic [9:0] H_ACT_FIRST = 10'd152;
    localparam logic [9:0] H_ACT_LAST  = 10'd790;
    // First scan read of a line; each read leads its pixels by 4 cycles.
    localparam logic [9:0] SLOT_BASE   = 10'd148;

    localparam logic [1:0] SWAP_IDLE    = 2'd0;
    localparam logic [1:0] SWAP_PENDING = 2'd1;
    localparam logic [1:0] SWAP_ACK     = 2'd2;
endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Writer handshake bundle: the writer is master, the arbiter is slave.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 17
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_err;

    modport master (output wr_valid, output wr_addr, output wr_data,
                    input wr_ready, input wr_err);
    modport slave  (input wr_valid, input wr_addr, input wr_data,
                    output wr_ready, output wr_err);
endinterface

// File: rtl/fb_pixel_shifter.sv
// Prefetch register and 4-byte pixel shifter; blanks pix_out outside the active window.
module fb_pixel_shifter #(
    parameter logic [9:0] SLOT_LAST = 10'd784
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic [31:0] ram_rdata,
    output logic [7:0]  pix_out
);
    import vga_pkg::*;

    localparam logic [9:0] CAP_FIRST  = SLOT_BASE + 10'd1;
    localparam logic [9:0] CAP_LAST   = SLOT_LAST + 10'd1;
    localparam logic [9:0] LOAD_FIRST = SLOT_BASE + 10'd3;
    localparam logic [9:0] LOAD_LAST  = SLOT_LAST + 10'd3;

    logic [31:0] prefetch_reg;
    logic [31:0] shift_reg;
    logic [7:0]  pix_reg;
    logic [9:0]  hc_next;
    logic        capture;
    logic        load;
    logic        visible;

    assign hc_next = hc + 10'd1;
    assign capture = (hc >= CAP_FIRST) && (hc <= CAP_LAST) && (hc[1:0] == CAP_FIRST[1:0]);
    assign load    = (hc >= LOAD_FIRST) && (hc <= LOAD_LAST) && (hc[1:0] == LOAD_FIRST[1:0]);
    // Blanking looks at the position being entered, since pix_out is registered.
    assign visible = (vc >= V_ACT_FIRST) && (vc <= V_ACT_LAST)
                  && (hc_next >= H_ACT_FIRST) && (hc_next <= H_ACT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            prefetch_reg <= '0;
            shift_reg    <= '0;
            pix_reg      <= '0;
        end else begin
            if (capture)
                prefetch_reg <= ram_rdata;
            if (load)
                shift_reg <= {8'h00, prefetch_reg[31:8]};
            else
                shift_reg <= {8'h00, shift_reg[31:8]};
            if (!visible)
                pix_reg <= '0;
            else if (load)
                pix_reg <= prefetch_reg[7:0];
            else
                pix_reg <= shift_reg[7:0];
        end
    end

    assign pix_out = pix_reg;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: fixed scan-out read slots, writer gets the rest,
// front/back buffer swap at frame end on request.
module vga_fb_arbiter #(
    parameter int HPIXELS        = vga_pkg::HPIXELS,
    parameter int VLINES         = vga_pkg::VLINES,
    parameter int WORDS_PER_LINE = 160,
    parameter int FB_WORDS       = 76800,
    parameter int ADDR_W         = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [9:0]          hc,
    input  logic [9:0]          vc,
    vga_fb_arbiter_if.slave     wr,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                front_sel,
    output logic                ram_en,
    output logic                ram_we,
    output logic [ADDR_W:0]     ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata,
    output logic [7:0]          pix_out
);
    import vga_pkg::SLOT_BASE;
    import vga_pkg::V_ACT_FIRST;
    import vga_pkg::V_ACT_LAST;
    import vga_pkg::SWAP_IDLE;
    import vga_pkg::SWAP_PENDING;
    import vga_pkg::SWAP_ACK;

    localparam logic [9:0]      H_LAST    = 10'(HPIXELS - 1);
    localparam logic [9:0]      V_LAST    = 10'(VLINES - 1);
    localparam logic [9:0]      SLOT_LAST = SLOT_BASE + 10'(4 * (WORDS_PER_LINE - 1));
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);
    localparam logic [ADDR_W:0] FB_SIZE   = (ADDR_W + 1)'(FB_WORDS);

    logic [ADDR_W-1:0] scan_addr_reg;
    logic [1:0]        swap_state_reg, swap_state_next;
    logic              front_reg, front_next;
    logic              wr_err_reg;
    logic              active_line;
    logic              scan_slot;
    logic              accept;
    logic              in_range;
    logic              frame_end;

    assign active_line = (vc >= V_ACT_FIRST) && (vc <= V_ACT_LAST);
    assign scan_slot   = reset && active_line && (hc >= SLOT_BASE) && (hc <= SLOT_LAST)
                      && (hc[1:0] == SLOT_BASE[1:0]);
    assign wr.wr_ready = reset & ~scan_slot;
    assign accept      = wr.wr_valid & wr.wr_ready;
    assign in_range    = {1'b0, wr.wr_addr} < FB_SIZE;
    assign frame_end   = (hc == H_LAST) && (vc == V_LAST);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = {~front_reg, wr.wr_addr};
        ram_wdata = wr.wr_data;
        if (scan_slot) begin
            ram_en   = 1'b1;
            ram_addr = {front_reg, scan_addr_reg};
        end else if (accept && in_range) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            scan_addr_reg <= '0;
        else if ((vc == '0) && (hc == '0))
            scan_addr_reg <= '0;
        else if (scan_slot && (scan_addr_reg != FB_LAST))
            scan_addr_reg <= scan_addr_reg + ADDR_W'(1);
    end

    // The toggle rides the PENDING->ACK transition so it lands exactly on the frame-end edge.
    always_comb begin
        swap_state_next = swap_state_reg;
        front_next      = front_reg;
        case (swap_state_reg)
            SWAP_IDLE:    if (swap_req) swap_state_next = SWAP_PENDING;
            SWAP_PENDING: if (frame_end) begin
                              swap_state_next = SWAP_ACK;
                              front_next      = ~front_reg;
                          end
            SWAP_ACK:     swap_state_next = SWAP_IDLE;
            default:      swap_state_next = SWAP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            swap_state_reg <= SWAP_IDLE;
            front_reg      <= 1'b0;
            wr_err_reg     <= 1'b0;
        end else begin
            swap_state_reg <= swap_state_next;
            front_reg      <= front_next;
            wr_err_reg     <= accept & ~in_range;
        end
    end

    assign swap_ack  = (swap_state_reg == SWAP_ACK);
    assign front_sel = front_reg;
    assign wr.wr_err = wr_err_reg;

    fb_pixel_shifter #(
        .SLOT_LAST (SLOT_LAST)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .hc        (hc),
        .vc        (vc),
        .ram_rdata (ram_rdata),
        .pix_out   (pix_out)
    );
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized scoreboard bench for vga_fb_arbiter with a screen-level reference model.
module tb_vga_fb_arbiter;
    localparam int ADDR_W   = 17;
    localparam int FB_WORDS = 76800;

    typedef struct {
        int               cyc;
        logic             we;
        logic [ADDR_W:0]  addr;
        logic [31:0]      data;
    } ram_exp_t;

    typedef struct {
        int          cyc;
        logic        ready;
        logic [7:0]  pix;
        logic        front;
        logic        ack;
        logic        err;
    } cyc_exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [9:0]       hc, vc;
    logic             swap_req, swap_ack, front_sel;
    logic             ram_en, ram_we;
    logic [ADDR_W:0]  ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata = '0;
    logic [7:0]       pix_out;

    vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) wr_bus ();

    vga_fb_arbiter #(
        .HPIXELS(800), .VLINES(521), .WORDS_PER_LINE(160),
        .FB_WORDS(FB_WORDS), .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hc        (hc),
        .vc        (vc),
        .wr        (wr_bus),
        .swap_req  (swap_req),
        .swap_ack  (swap_ack),
        .front_sel (front_sel),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .pix_out   (pix_out)
    );

    always #5 clk = ~clk;

    // Initial RAM contents; front word 0 carries the known pixel pattern.
    function automatic logic [31:0] pat(input int a);
        logic [31:0] v;
        v = (32'(a) * 32'h9E3779B1) ^ 32'hA5C30F00;
        return (a == 0) ? 32'h44332211 : v;
    endfunction

    // Synchronous single-port RAM driven by the DUT.
    logic [31:0] ram_mem [int];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                ram_mem[int'(ram_addr)] = ram_wdata;
            else
                ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : pat(int'(ram_addr));
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [int];
    logic [31:0] slot_word [800];
    ram_exp_t    ram_q[$];
    cyc_exp_t    cyc_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          scan_cnt = 0;
    int          ack_cyc = -10;
    logic        front_m = 1'b0;
    logic        armed = 1'b0;
    logic        hold_off = 1'b0;
    logic        err_next = 1'b0;

    function automatic logic [31:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input int c);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
        end
    endtask

    task automatic drive_cycle(input int h, input int v, input logic rst_n, input int force_addr);
        ram_exp_t    r;
        cyc_exp_t    e;
        logic        slot, acc, inr, in_win;
        int          addr, sel, x;
        logic [31:0] w;
        logic [ADDR_W:0] a;

        cyc++;
        if (cyc == ack_cyc + 1)
            swap_req = 1'b0;
        hc    = 10'(h);
        vc    = 10'(v);
        reset = rst_n;
        if (force_addr >= 0) begin
            wr_bus.wr_valid = 1'b1;
            addr = force_addr;
        end else begin
            wr_bus.wr_valid = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 15));
            if (sel == 0)
                addr = int'($urandom_range(FB_WORDS, (1 << ADDR_W) - 1));
            else if (sel < 4)
                addr = int'($urandom_range(0, FB_WORDS - 1));
            else
                addr = int'($urandom_range(0, 479));
        end
        wr_bus.wr_addr = ADDR_W'(addr);
        wr_bus.wr_data = $urandom();

        slot   = rst_n && v >= 37 && v <= 515 && h >= 148 && h <= 784 && (h % 4 == 0);
        acc    = wr_bus.wr_valid && rst_n && !slot;
        inr    = addr < FB_WORDS;
        in_win = v >= 37 && v <= 515 && h >= 152 && h <= 790;

        e.cyc   = cyc;
        e.ready = rst_n && !slot;
        e.front = front_m;
        e.ack   = (cyc == ack_cyc);
        e.err   = err_next;
        e.pix   = 8'h00;
        if (in_win) begin
            x = h - 152;
            w = slot_word[h - (x % 4) - 4];
            e.pix = w[8 * (x % 4) +: 8];
        end

        if (slot) begin
            a = {front_m, ADDR_W'(scan_cnt)};
            slot_word[h] = ref_read(int'(a));
            r.cyc = cyc; r.we = 1'b0; r.addr = a; r.data = '0;
            ram_q.push_back(r);
        end
        if (acc && inr) begin
            a = {~front_m, ADDR_W'(addr)};
            ref_mem[int'(a)] = wr_bus.wr_data;
            r.cyc = cyc; r.we = 1'b1; r.addr = a; r.data = wr_bus.wr_data;
            ram_q.push_back(r);
        end
        cyc_q.push_back(e);

        // State changes taking effect at the edge closing this cycle.
        if (!rst_n) begin
            scan_cnt = 0; front_m = 1'b0; armed = 1'b0; hold_off = 1'b0; err_next = 1'b0;
        end else begin
            if (h == 0 && v == 0)
                scan_cnt = 0;
            else if (slot)
                scan_cnt++;
            if (h == 799 && v == 520 && armed) begin
                front_m  = ~front_m;
                ack_cyc  = cyc + 1;
                armed    = 1'b0;
                hold_off = 1'b1;
            end
            if (!swap_req)
                hold_off = 1'b0;
            else if (!hold_off)
                armed = 1'b1;
            err_next = acc && !inr;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        cyc_exp_t e;
        ram_exp_t r;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("wr_ready", 64'(wr_bus.wr_ready), 64'(e.ready), e.cyc);
                check("pix_out", 64'(pix_out), 64'(e.pix), e.cyc);
                check("front_sel", 64'(front_sel), 64'(e.front), e.cyc);
                check("swap_ack", 64'(swap_ack), 64'(e.ack), e.cyc);
                check("wr_err", 64'(wr_bus.wr_err), 64'(e.err), e.cyc);
                if (ram_q.size() > 0 && ram_q[0].cyc == e.cyc) begin
                    r = ram_q.pop_front();
                    check("ram_en", 64'(ram_en), 64'(1'b1), e.cyc);
                    check("ram_we", 64'(ram_we), 64'(r.we), e.cyc);
                    check("ram_addr", 64'(ram_addr), 64'(r.addr), e.cyc);
                    if (r.we)
                        check("ram_wdata", 64'(ram_wdata), 64'(r.data), e.cyc);
                end else begin
                    check("ram_en_idle", 64'(ram_en), 64'(1'b0), e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int lines[10] = '{0, 36, 37, 38, 39, 100, 514, 515, 516, 520};
        int fa;
        reset           = 1'b0;
        hc              = '0;
        vc              = '0;
        swap_req        = 1'b0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_addr  = '0;
        wr_bus.wr_data  = '0;
        for (int i = 0; i < 800; i++)
            slot_word[i] = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++)
            drive_cycle(i, 0, 1'b0, -1);

        for (int f = 0; f < 4; f++) begin
            for (int li = 0; li < 10; li++) begin
                for (int h = 0; h < 800; h++) begin
                    fa = -1;
                    if (f == 0 && lines[li] == 0 && h == 20) fa = FB_WORDS;
                    if (f == 0 && lines[li] == 0 && h == 21) fa = FB_WORDS - 1;
                    if (f == 2 && lines[li] == 38 && h == 300) fa = FB_WORDS;
                    if (f == 0 && lines[li] == 100 && h == 0) swap_req = 1'b1;
                    if (f == 1 && lines[li] == 520 && h == 799) swap_req = 1'b1;
                    drive_cycle(h, lines[li], 1'b1, fa);
                end
            end
        end

        for (int i = 0; i < 10 && cyc_q.size() > 0; i++)
            @(negedge clk);
        check("cyc_q_drained", 64'(cyc_q.size()), 64'd0, cyc);
        check("ram_q_drained", 64'(ram_q.size()), 64'd0, cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
